// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// Optional looping behaviour is selected with FETCH_SEQ_WRAP_EN (see fetch_sequencer).
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2,
      ST_DONE  = 2'd3
   } fetch_state_t;

   localparam int INSTR_W        = 32;
   localparam int DEF_ADDR_W     = 3;
   localparam int DEF_PROG_LEN   = 5;
   localparam int DEF_START_ADDR = 1;
   localparam int DEF_CNT_W      = 8;

   localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

   function automatic logic is_busy(input fetch_state_t st);
      return (st == ST_ISSUE) || (st == ST_RESP);
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory, decode handshake and redirect signals of the fetch sequencer.
// master = sequencer side, slave = memory/decode side.
interface fetch_sequencer_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) ();

   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               instr_ready;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;

   modport master (
      output imem_addr,
      output instr,
      output instr_valid,
      input  imem_rdata,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_addr
   );

   modport slave (
      input  imem_addr,
      input  instr,
      input  instr_valid,
      output imem_rdata,
      output instr_ready,
      output redirect_valid,
      output redirect_addr
   );

endinterface

// File: rtl/fetch_pc_unit.sv
// Program-counter register with load/increment and address range checks
// for the fetch sequencer.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int PROG_LEN = DEF_PROG_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_val,
   input  logic              inc,
   input  logic [ADDR_W-1:0] check_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              last_addr,
   output logic              check_in_range
);

   // One extra bit so PROG_LEN == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   PROG_LEN_W = (ADDR_W+1)'(PROG_LEN);
   localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);

   logic [ADDR_W-1:0] pc_r;

   // PC register: load has priority over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_r <= {ADDR_W{1'b0}};
      end else if (load) begin
         pc_r <= load_val;
      end else if (inc) begin
         pc_r <= pc_r + ADDR_W'(1'b1);
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc             = pc_r;
   assign last_addr      = (pc_r == LAST_PC);
   assign check_in_range = ({1'b0, check_addr} < PROG_LEN_W);

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches from a registered-read memory and
// hands words to decode over valid/ready. Define FETCH_SEQ_WRAP_EN to loop instead of halting.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int PROG_LEN   = DEF_PROG_LEN,
   parameter int START_ADDR = DEF_START_ADDR,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   fetch_sequencer_if.master bus,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  retired
);

   localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);

   fetch_state_t      state_r;
   fetch_state_t      state_next_s;
   logic              valid_r;
   logic              valid_next_s;
   logic              busy_r;
   logic              done_r;
   logic [CNT_W-1:0]  retired_r;
   logic              retire_s;
   logic              clear_retired_s;
   logic              pc_load_s;
   logic [ADDR_W-1:0] pc_load_val_s;
   logic              pc_inc_s;
   logic [ADDR_W-1:0] pc_s;
   logic              last_addr_s;
   logic              redirect_in_range_s;

   fetch_pc_unit #(
      .ADDR_W   (ADDR_W),
      .PROG_LEN (PROG_LEN)
   ) u_pc (
      .clk            (clk),
      .rst            (rst),
      .load           (pc_load_s),
      .load_val       (pc_load_val_s),
      .inc            (pc_inc_s),
      .check_addr     (bus.redirect_addr),
      .pc             (pc_s),
      .last_addr      (last_addr_s),
      .check_in_range (redirect_in_range_s)
   );

   // Next-state, PC control and handshake decode; redirect outranks the handshake.
   always_comb begin
      state_next_s    = state_r;
      valid_next_s    = valid_r;
      pc_load_s       = 1'b0;
      pc_load_val_s   = pc_s;
      pc_inc_s        = 1'b0;
      retire_s        = 1'b0;
      clear_retired_s = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               pc_load_s       = 1'b1;
               pc_load_val_s   = START_PC;
               clear_retired_s = 1'b1;
               state_next_s    = ST_ISSUE;
            end else begin
               state_next_s = state_r;
            end
         end
         ST_ISSUE, ST_RESP: begin
            if (bus.redirect_valid) begin
               valid_next_s = 1'b0;
               if (redirect_in_range_s) begin
                  pc_load_s     = 1'b1;
                  pc_load_val_s = bus.redirect_addr;
                  state_next_s  = ST_ISSUE;
               end else begin
`ifdef FETCH_SEQ_WRAP_EN
                  pc_load_s     = 1'b1;
                  pc_load_val_s = START_PC;
                  state_next_s  = ST_ISSUE;
`else
                  state_next_s  = ST_DONE;
`endif
               end
            end else if (state_r == ST_ISSUE) begin
               state_next_s = ST_RESP;
               valid_next_s = 1'b1;
            end else if (valid_r && bus.instr_ready) begin
               retire_s     = 1'b1;
               valid_next_s = 1'b0;
               if (last_addr_s) begin
`ifdef FETCH_SEQ_WRAP_EN
                  pc_load_s     = 1'b1;
                  pc_load_val_s = START_PC;
                  state_next_s  = ST_ISSUE;
`else
                  state_next_s  = ST_DONE;
`endif
               end else begin
                  pc_inc_s     = 1'b1;
                  state_next_s = ST_ISSUE;
               end
            end else begin
               state_next_s = ST_RESP;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            valid_next_s = 1'b0;
         end
      endcase
   end

   // State, valid and status flags; status is registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         valid_r <= valid_next_s;
         busy_r  <= is_busy(state_next_s);
         done_r  <= (state_next_s == ST_DONE);
      end
   end

   // Retired-instruction counter, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (clear_retired_s) begin
         retired_r <= {CNT_W{1'b0}};
      end else if (retire_s && (retired_r != {CNT_W{1'b1}})) begin
         retired_r <= retired_r + CNT_W'(1'b1);
      end else begin
         retired_r <= retired_r;
      end
   end

   // The memory output register is the instruction register: the address is held
   // through RESP, so the word stays stable while decode stalls.
   assign bus.instr       = valid_r ? bus.imem_rdata : NOP_WORD;
   assign bus.instr_valid = valid_r;
   assign bus.imem_addr   = pc_s;
   assign pc              = pc_s;
   assign busy            = busy_r;
   assign done            = done_r;
   assign retired         = retired_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a registered-read memory model and
// an expected-instruction scoreboard. Covers the looping mode when FETCH_SEQ_WRAP_EN is defined.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   localparam int ADDR_W     = 3;
   localparam int PROG_LEN   = 5;
   localparam int START_ADDR = 1;
   localparam int CNT_W      = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] pc;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  retired;

   fetch_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_sequencer #(
      .ADDR_W(ADDR_W), .PROG_LEN(PROG_LEN), .START_ADDR(START_ADDR), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .pc(pc), .busy(busy), .done(done), .retired(retired)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:7];
   always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr];

   int checks = 0;
   int failures = 0;
   logic [31:0]       exp_instr_q[$];
   logic [ADDR_W-1:0] exp_pc_q[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic push_word(input logic [ADDR_W-1:0] a);
      case (a)
         3'd1:    exp_instr_q.push_back(32'h54410003);
         3'd2:    exp_instr_q.push_back(32'h51010001);
         3'd3:    exp_instr_q.push_back(32'h90640800);
         3'd4:    exp_instr_q.push_back(32'hB1480800);
         default: exp_instr_q.push_back(32'h00000000);
      endcase
      exp_pc_q.push_back(a);
   endtask

   task automatic push_program();
      for (int a = START_ADDR; a < PROG_LEN; a++) push_word(ADDR_W'(a));
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.instr_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_addr = 3'd0;
      repeat (3) step();
      checks++; if (pc !== 3'd0) begin failures++; $display("FAIL reset_pc: got %0d expected 0", pc); end
      checks++; if (bus.imem_addr !== 3'd0) begin failures++; $display("FAIL reset_imem_addr: got %0d expected 0", bus.imem_addr); end
      checks++; if (bus.instr !== NOP_WORD) begin failures++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
      checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%b done=%b expected 0/0", busy, done); end
      checks++; if (retired !== 8'd0) begin failures++; $display("FAIL reset_retired: got %0d expected 0", retired); end
      rst = 1'b1;
      step();
   endtask

`ifdef FETCH_SEQ_WRAP_EN
   task automatic test_wrap();
      int  n = 0;
      logic saw_done = 1'b0;
      bus.instr_ready = 1'b1;
      for (int k = 0; k < 10; k++) push_word(ADDR_W'(1 + (k % 4)));
      pulse_start();
      for (int c = 0; c < 60 && n < 10; c++) begin
         if (done) saw_done = 1'b1;
         if (bus.instr_valid) begin
            checks++;
            if (bus.instr !== exp_instr_q[0] || pc !== exp_pc_q[0]) begin failures++; $display("FAIL wrap_instr: got %h@%0d expected %h@%0d", bus.instr, pc, exp_instr_q[0], exp_pc_q[0]); end
            void'(exp_instr_q.pop_front()); void'(exp_pc_q.pop_front());
            n++;
         end
         step();
      end
      checks++; if (n != 10) begin failures++; $display("FAIL wrap_timeout: got %0d transfers expected 10", n); end
      checks++; if (saw_done) begin failures++; $display("FAIL wrap_done: got done=1 expected never"); end
      checks++; if (retired !== 8'd10) begin failures++; $display("FAIL wrap_retired: got %0d expected 10", retired); end
      bus.instr_ready = 1'b0;
      for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
      bus.redirect_valid = 1'b1; bus.redirect_addr = 3'd6;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (pc !== 3'd1 || busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL wrap_redirect: got pc=%0d busy=%b done=%b expected 1/1/0", pc, busy, done); end
      checks++; if (retired !== 8'd10) begin failures++; $display("FAIL wrap_redirect_retired: got %0d expected 10", retired); end
   endtask
`else
   task automatic test_sequence();
      logic prev_valid = 1'b0;
      bus.instr_ready = 1'b1;
      push_program();
      pulse_start();
      checks++; if (busy !== 1'b1 || pc !== 3'd1 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL seq_issue: got busy=%b pc=%0d valid=%b expected 1/1/0", busy, pc, bus.instr_valid); end
      step();
      checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL seq_latency: got valid=%b expected 1", bus.instr_valid); end
      for (int c = 0; c < 40; c++) begin
         if (bus.instr_valid) begin
            checks++; if (prev_valid) begin failures++; $display("FAIL seq_gap: got valid on consecutive cycles expected one-cycle gap"); end
            checks++;
            if (exp_instr_q.size() == 0) begin failures++; $display("FAIL seq_extra: got %h@%0d expected nothing", bus.instr, pc); end
            else begin
               if (bus.instr !== exp_instr_q[0] || pc !== exp_pc_q[0]) begin failures++; $display("FAIL seq_instr: got %h@%0d expected %h@%0d", bus.instr, pc, exp_instr_q[0], exp_pc_q[0]); end
               void'(exp_instr_q.pop_front()); void'(exp_pc_q.pop_front());
            end
         end
         prev_valid = bus.instr_valid;
         if (exp_instr_q.size() == 0 && done) break;
         step();
      end
      checks++; if (exp_instr_q.size() != 0 || done !== 1'b1) begin failures++; $display("FAIL seq_timeout: got %0d pending done=%b expected 0/1", exp_instr_q.size(), done); end
      checks++; if (retired !== 8'd4) begin failures++; $display("FAIL seq_retired: got %0d expected 4", retired); end
      checks++; if (busy !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL seq_end: got busy=%b valid=%b expected 0/0", busy, bus.instr_valid); end
   endtask

   task automatic test_stall();
      bus.instr_ready = 1'b0;
      push_program();
      pulse_start();
      for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
      bus.instr_ready = 1'b1;
      checks++; if (bus.instr_valid !== 1'b1 || bus.instr !== exp_instr_q[0]) begin failures++; $display("FAIL stall_first: got %h valid=%b expected %h", bus.instr, bus.instr_valid, exp_instr_q[0]); end
      void'(exp_instr_q.pop_front()); void'(exp_pc_q.pop_front());
      step();
      bus.instr_ready = 1'b0;
      for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
      for (int k = 0; k < 5; k++) begin
         checks++; if (bus.instr !== 32'h51010001 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL stall_instr: got %h valid=%b expected 51010001/1", bus.instr, bus.instr_valid); end
         checks++; if (pc !== 3'd2 || bus.imem_addr !== 3'd2 || retired !== 8'd1) begin failures++; $display("FAIL stall_hold: got pc=%0d addr=%0d retired=%0d expected 2/2/1", pc, bus.imem_addr, retired); end
         step();
      end
      bus.instr_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (exp_instr_q.size() == 0) begin failures++; $display("FAIL stall_extra: got %h@%0d expected nothing", bus.instr, pc); end
            else begin
               if (bus.instr !== exp_instr_q[0] || pc !== exp_pc_q[0]) begin failures++; $display("FAIL stall_instr_seq: got %h@%0d expected %h@%0d", bus.instr, pc, exp_instr_q[0], exp_pc_q[0]); end
               void'(exp_instr_q.pop_front()); void'(exp_pc_q.pop_front());
            end
         end
         if (exp_instr_q.size() == 0 && done) break;
         step();
      end
      checks++; if (exp_instr_q.size() != 0 || done !== 1'b1 || retired !== 8'd4) begin failures++; $display("FAIL stall_end: got %0d pending done=%b retired=%0d expected 0/1/4", exp_instr_q.size(), done, retired); end
   endtask

   task automatic test_redirect();
      logic redir_done = 1'b0;
      bus.instr_ready = 1'b1;
      push_word(3'd1); push_word(3'd2);
      push_program();
      pulse_start();
      for (int c = 0; c < 60; c++) begin
         if (bus.instr_valid && pc == 3'd3 && !redir_done) begin
            bus.redirect_valid = 1'b1; bus.redirect_addr = 3'd1;
            redir_done = 1'b1;
            step();
            bus.redirect_valid = 1'b0;
            checks++; if (bus.instr_valid !== 1'b0 || pc !== 3'd1 || busy !== 1'b1) begin failures++; $display("FAIL redir_state: got valid=%b pc=%0d busy=%b expected 0/1/1", bus.instr_valid, pc, busy); end
            checks++; if (retired !== 8'd2) begin failures++; $display("FAIL redir_retired: got %0d expected 2", retired); end
         end else if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (exp_instr_q.size() == 0) begin failures++; $display("FAIL redir_extra: got %h@%0d expected nothing", bus.instr, pc); end
            else begin
               if (bus.instr !== exp_instr_q[0] || pc !== exp_pc_q[0]) begin failures++; $display("FAIL redir_instr: got %h@%0d expected %h@%0d", bus.instr, pc, exp_instr_q[0], exp_pc_q[0]); end
               void'(exp_instr_q.pop_front()); void'(exp_pc_q.pop_front());
            end
         end
         if (exp_instr_q.size() == 0 && done) break;
         step();
      end
      checks++; if (!redir_done || exp_instr_q.size() != 0 || done !== 1'b1) begin failures++; $display("FAIL redir_timeout: got redirected=%b pending=%0d done=%b expected 1/0/1", redir_done, exp_instr_q.size(), done); end
      checks++; if (retired !== 8'd6) begin failures++; $display("FAIL redir_total: got %0d expected 6", retired); end
   endtask

   task automatic test_redirect_out_of_range();
      bus.instr_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
      checks++; if (bus.instr !== 32'h54410003 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL oor_first: got %h valid=%b expected 54410003/1", bus.instr, bus.instr_valid); end
      step();
      bus.redirect_valid = 1'b1; bus.redirect_addr = 3'd6;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (done !== 1'b1 || busy !== 1'b0 || bus.instr_valid !== 1'b0) begin failures++; $display("FAIL oor_done: got done=%b busy=%b valid=%b expected 1/0/0", done, busy, bus.instr_valid); end
      checks++; if (retired !== 8'd1 || pc !== 3'd2) begin failures++; $display("FAIL oor_hold: got retired=%0d pc=%0d expected 1/2", retired, pc); end
      bus.redirect_valid = 1'b1; bus.redirect_addr = 3'd1;
      step();
      bus.redirect_valid = 1'b0;
      checks++; if (done !== 1'b1 || pc !== 3'd2) begin failures++; $display("FAIL oor_ignore_in_done: got done=%b pc=%0d expected 1/2", done, pc); end
      bus.instr_ready = 1'b0;
      start = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_addr = 3'd3;
      step();
      start = 1'b0; bus.redirect_valid = 1'b0;
      checks++; if (busy !== 1'b1 || done !== 1'b0 || pc !== 3'd1 || bus.imem_addr !== 3'd1) begin failures++; $display("FAIL oor_restart: got busy=%b done=%b pc=%0d addr=%0d expected 1/0/1/1", busy, done, pc, bus.imem_addr); end
      checks++; if (retired !== 8'd0) begin failures++; $display("FAIL oor_restart_retired: got %0d expected 0", retired); end
      for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
      checks++; if (bus.instr !== 32'h54410003 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL oor_refetch: got %h valid=%b expected 54410003/1", bus.instr, bus.instr_valid); end
   endtask

   task automatic test_reset_mid_resp();
      logic active = 1'b0;
      bus.instr_ready = 1'b1;
      step();
      bus.instr_ready = 1'b0;
      for (int c = 0; c < 10 && !bus.instr_valid; c++) step();
      checks++; if (retired !== 8'd1 || pc !== 3'd2 || bus.instr_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got retired=%0d pc=%0d valid=%b expected 1/2/1", retired, pc, bus.instr_valid); end
      rst = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== NOP_WORD) begin failures++; $display("FAIL rstmid_out: got valid=%b instr=%h expected 0/0", bus.instr_valid, bus.instr); end
      checks++; if (pc !== 3'd0 || bus.imem_addr !== 3'd0 || retired !== 8'd0) begin failures++; $display("FAIL rstmid_regs: got pc=%0d addr=%0d retired=%0d expected 0/0/0", pc, bus.imem_addr, retired); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rstmid_flags: got busy=%b done=%b expected 0/0", busy, done); end
      bus.instr_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (bus.instr_valid || busy) active = 1'b1;
      end
      checks++; if (active) begin failures++; $display("FAIL rstmid_idle: got activity expected none before start"); end
      push_program();
      pulse_start();
      for (int c = 0; c < 40; c++) begin
         if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (exp_instr_q.size() == 0) begin failures++; $display("FAIL rstmid_extra: got %h@%0d expected nothing", bus.instr, pc); end
            else begin
               if (bus.instr !== exp_instr_q[0] || pc !== exp_pc_q[0]) begin failures++; $display("FAIL rstmid_instr: got %h@%0d expected %h@%0d", bus.instr, pc, exp_instr_q[0], exp_pc_q[0]); end
               void'(exp_instr_q.pop_front()); void'(exp_pc_q.pop_front());
            end
         end
         if (exp_instr_q.size() == 0 && done) break;
         step();
      end
      checks++; if (exp_instr_q.size() != 0 || done !== 1'b1 || retired !== 8'd4) begin failures++; $display("FAIL rstmid_rerun: got pending=%0d done=%b retired=%0d expected 0/1/4", exp_instr_q.size(), done, retired); end
   endtask

   task automatic test_saturation();
      int model = 0;
      bus.instr_ready = 1'b1;
      pulse_start();
      for (int c = 0; c < 3000 && model < 260; c++) begin
         if (bus.instr_valid && pc == 3'd4) begin
            bus.redirect_valid = 1'b1; bus.redirect_addr = 3'd1;
         end else begin
            bus.redirect_valid = 1'b0;
            if (bus.instr_valid) begin
               if (model == 200) begin
                  checks++; if (retired !== 8'd200) begin failures++; $display("FAIL sat_mid: got %0d expected 200", retired); end
               end
               model++;
            end
         end
         step();
      end
      bus.redirect_valid = 1'b0;
      checks++; if (model != 260) begin failures++; $display("FAIL sat_timeout: got %0d transfers expected 260", model); end
      checks++; if (retired !== 8'd255) begin failures++; $display("FAIL sat_value: got %0d expected 255", retired); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL sat_done: got done=%b expected 0", done); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 8; a++) mem[a] = 32'hDEAD0000 | a;
      mem[0] = 32'h00000000;
      mem[1] = 32'h54410003;
      mem[2] = 32'h51010001;
      mem[3] = 32'h90640800;
      mem[4] = 32'hB1480800;
      test_reset();
`ifdef FETCH_SEQ_WRAP_EN
      test_wrap();
`else
      test_sequence();
      test_stall();
      test_redirect();
      test_redirect_out_of_range();
      test_reset_mid_resp();
      test_saturation();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
